// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback path.
// The requester count here is the default width of the writeback arbiter.
package regfile_pkg;
    localparam int          REG_AW   = 5;
    localparam int          REG_DW   = 32;
    localparam int          REG_NUM  = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_RA   = 5'd31;
    localparam int          N_WB_REQ = 3;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Generic round-robin arbiter.
// It grants the first asserted request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o
);

    logic w_found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && req_i[idx]) begin
                w_found      = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback units.
// It also tracks issued-but-uncommitted destinations so the decoder can detect hazards.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = N_WB_REQ,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*AW-1:0] req_wa_i,
    input  logic [N_REQ*DW-1:0] req_wd_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic                rsv_valid_i,
    input  logic [AW-1:0]       rsv_wa_i,
    input  logic [AW-1:0]       chk_ra1_i,
    input  logic [AW-1:0]       chk_ra2_i,
    output logic                hazard_o,
    output logic                RegWrite_o,
    output logic [AW-1:0]       wa_o,
    output logic [DW-1:0]       wd_o,
    output logic [2**AW-1:0]    pending_o,
    output logic                rsv_err_o
);

    localparam int PW   = $clog2(N_REQ);
    localparam int NREG = 2**AW;

    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_gidx;
    logic             w_take;
    logic [AW-1:0]    w_gwa;
    logic [DW-1:0]    w_gwd;
    logic [PW-1:0]    r_rr_ptr;
    logic [NREG-1:0]  r_pending;
    logic [NREG-1:0]  w_pending_next;
    logic             r_rsv_err;
    logic             w_rsv_collide;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (r_rr_ptr),
        .grant_o     (w_grant),
        .grant_idx_o (w_gidx)
    );

    assign req_ready_o = rst_n ? w_grant : '0;
    assign w_take      = |req_ready_o;
    assign w_gwa       = req_wa_i[int'(w_gidx)*AW +: AW];
    assign w_gwd       = req_wd_i[int'(w_gidx)*DW +: DW];

    // A grant to r0 still consumes the request and advances the pointer, but never writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            RegWrite_o <= 1'b0;
            wa_o       <= '0;
            wd_o       <= '0;
        end else if (w_take) begin
            r_rr_ptr   <= (w_gidx == PW'(N_REQ-1)) ? '0 : w_gidx + PW'(1);
            RegWrite_o <= (w_gwa != '0);
            wa_o       <= w_gwa;
            wd_o       <= w_gwd;
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

    // Set is applied after clear so a fresh reservation survives a same-cycle commit.
    always_comb begin
        w_pending_next = r_pending;
        w_rsv_collide  = 1'b0;
        if (RegWrite_o) begin
            w_pending_next[wa_o] = 1'b0;
        end
        if (rsv_valid_i && (rsv_wa_i != '0)) begin
            w_pending_next[rsv_wa_i] = 1'b1;
            if (r_pending[rsv_wa_i] && !(RegWrite_o && (wa_o == rsv_wa_i))) begin
                w_rsv_collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_rsv_collide) begin
                r_rsv_err <= 1'b1;
            end
        end
    end

    assign hazard_o  = ((chk_ra1_i != '0) && r_pending[chk_ra1_i]) ||
                       ((chk_ra2_i != '0) && r_pending[chk_ra2_i]);
    assign pending_o = r_pending;
    assign rsv_err_o = r_rsv_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter and pending-write scoreboard.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_wa;
    logic [95:0] req_wd;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_wa;
    logic [4:0]  chk_ra1;
    logic [4:0]  chk_ra2;
    logic        hazard;
    logic        reg_write;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pending;
    logic        rsv_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rfModel [32];

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002;
    localparam logic [31:0] B0 = 32'hB000_0000;
    localparam logic [31:0] B1 = 32'hB000_0001;
    localparam logic [31:0] C0 = 32'hC000_0000;
    localparam logic [31:0] C1 = 32'hC000_0001;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] P8 = 32'h0000_0100;
    localparam logic [31:0] P9 = 32'h0000_0200;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  wa2;
        logic [31:0] wd2;
        logic        rsv;
        logic [4:0]  rwa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [2:0]  expReady;
        logic        expHazard;
        logic        expRw;
        logic [4:0]  expWa;
        logic [31:0] expWd;
        logic        expErr;
        logic [31:0] expPend;
    } vec_t;

    vec_t vecs[$];

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_wa_i    (req_wa),
        .req_wd_i    (req_wd),
        .req_ready_o (req_ready),
        .rsv_valid_i (rsv_valid),
        .rsv_wa_i    (rsv_wa),
        .chk_ra1_i   (chk_ra1),
        .chk_ra2_i   (chk_ra2),
        .hazard_o    (hazard),
        .RegWrite_o  (reg_write),
        .wa_o        (wa),
        .wd_o        (wd),
        .pending_o   (pending),
        .rsv_err_o   (rsv_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream register file, captured on the same edge the scoreboard clears.
    always @(posedge clk) begin
        if (reg_write) begin
            rfModel[wa] <= wd;
        end
    end

    function automatic void addVec(
        input logic [2:0] valid,
        input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic [4:0] wa2, input logic [31:0] wd2,
        input logic rsv, input logic [4:0] rwa,
        input logic [4:0] ra1, input logic [4:0] ra2,
        input logic [2:0] expReady, input logic expHazard, input logic expRw,
        input logic [4:0] expWa, input logic [31:0] expWd,
        input logic expErr, input logic [31:0] expPend);
        vec_t v;
        v.valid = valid; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.wa2 = wa2; v.wd2 = wd2; v.rsv = rsv; v.rwa = rwa; v.ra1 = ra1; v.ra2 = ra2;
        v.expReady = expReady; v.expHazard = expHazard; v.expRw = expRw;
        v.expWa = expWa; v.expWd = expWd; v.expErr = expErr; v.expPend = expPend;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        checks++;
        if (act !== expVal) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expVal);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req_valid = v.valid;
        req_wa    = {v.wa2, v.wa1, v.wa0};
        req_wd    = {v.wd2, v.wd1, v.wd0};
        rsv_valid = v.rsv;
        rsv_wa    = v.rwa;
        chk_ra1   = v.ra1;
        chk_ra2   = v.ra2;
        #1;
    endtask

    task automatic checkRow(input int i, input vec_t v);
        checkOutput($sformatf("row%0d_ready", i), 32'(req_ready), 32'(v.expReady));
        checkOutput($sformatf("row%0d_hazard", i), 32'(hazard), 32'(v.expHazard));
        checkOutput($sformatf("row%0d_regwrite", i), 32'(reg_write), 32'(v.expRw));
        checkOutput($sformatf("row%0d_wa", i), 32'(wa), 32'(v.expWa));
        checkOutput($sformatf("row%0d_wd", i), wd, v.expWd);
        checkOutput($sformatf("row%0d_rsverr", i), 32'(rsv_err), 32'(v.expErr));
        checkOutput($sformatf("row%0d_pending", i), pending, v.expPend);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            rfModel[r] = 32'h0;
        end

        // Round robin with all three requesters busy, then partial request patterns.
        addVec(3'b111, 5'd1, A0, 5'd2, B0, 5'd3, C0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 5'd0, Z,  1'b0, Z);
        addVec(3'b111, 5'd1, A1, 5'd2, B0, 5'd3, C0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b1, 5'd1, A0, 1'b0, Z);
        addVec(3'b111, 5'd1, A1, 5'd2, B0, 5'd3, C0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 1'b1, 5'd2, B0, 1'b0, Z);
        addVec(3'b111, 5'd1, A1, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b1, 5'd3, C0, 1'b0, Z);
        addVec(3'b000, 5'd1, A1, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 5'd1, A1, 1'b0, Z);
        addVec(3'b000, 5'd1, A1, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd1, A1, 1'b0, Z);
        addVec(3'b101, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 1'b0, 5'd1, A1, 1'b0, Z);
        addVec(3'b001, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b1, 5'd3, C1, 1'b0, Z);
        addVec(3'b000, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 5'd1, A2, 1'b0, Z);
        // Reserve r8, commit it through requester 1, hazard clears two cycles after acceptance.
        addVec(3'b000, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b1, 5'd8, 5'd8, 5'd0, 3'b000, 1'b0, 1'b0, 5'd1, A2, 1'b0, Z);
        addVec(3'b000, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd8, 5'd0, 3'b000, 1'b1, 1'b0, 5'd1, A2, 1'b0, P8);
        addVec(3'b000, 5'd1, A2, 5'd2, B1, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd8, 3'b000, 1'b1, 1'b0, 5'd1, A2, 1'b0, P8);
        addVec(3'b010, 5'd1, A2, 5'd8, DB, 5'd3, C1, 1'b0, 5'd0, 5'd8, 5'd0, 3'b010, 1'b1, 1'b0, 5'd1, A2, 1'b0, P8);
        addVec(3'b000, 5'd1, A2, 5'd8, DB, 5'd3, C1, 1'b0, 5'd0, 5'd8, 5'd0, 3'b000, 1'b1, 1'b1, 5'd8, DB, 1'b0, P8);
        addVec(3'b000, 5'd1, A2, 5'd8, DB, 5'd3, C1, 1'b0, 5'd0, 5'd8, 5'd0, 3'b000, 1'b0, 1'b0, 5'd8, DB, 1'b0, Z);
        // Write and reserve of r0 are both no-ops on the register file and scoreboard.
        addVec(3'b001, 5'd0, 32'h1234, 5'd8, DB, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 5'd8, DB, 1'b0, Z);
        addVec(3'b000, 5'd0, 32'h1234, 5'd8, DB, 5'd3, C1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b0, Z);
        addVec(3'b000, 5'd0, 32'h1234, 5'd8, DB, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b0, Z);
        // Same-cycle commit and re-reserve of r9, then a genuine double reservation.
        addVec(3'b000, 5'd0, 32'h1234, 5'd8, DB, 5'd3, C1, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b0, Z);
        addVec(3'b010, 5'd0, 32'h1234, 5'd9, 32'h99, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b0, P9);
        addVec(3'b000, 5'd0, 32'h1234, 5'd9, 32'h99, 5'd3, C1, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, P9);
        addVec(3'b000, 5'd0, 32'h1234, 5'd9, 32'h99, 5'd3, C1, 1'b1, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd9, 32'h99, 1'b0, P9);
        addVec(3'b000, 5'd0, 32'h1234, 5'd9, 32'h99, 5'd3, C1, 1'b0, 5'd0, 5'd0, 5'd9, 3'b000, 1'b1, 1'b0, 5'd9, 32'h99, 1'b1, P9);

        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_wa    = {5'd3, 5'd2, 5'd1};
        req_wd    = {C0, B0, A0};
        rsv_valid = 1'b0;
        rsv_wa    = 5'd0;
        chk_ra1   = 5'd0;
        chk_ra2   = 5'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_regwrite", 32'(reg_write), 32'h0);
        checkOutput("reset_wa", 32'(wa), 32'h0);
        checkOutput("reset_wd", wd, 32'h0);
        checkOutput("reset_pending", pending, 32'h0);
        checkOutput("reset_rsverr", 32'(rsv_err), 32'h0);
        rst_n     = 1'b1;
        req_valid = 3'b000;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkRow(i, vecs[i]);
        end

        checkOutput("regfile_r8", rfModel[8], DB);
        checkOutput("regfile_r9", rfModel[9], 32'h99);

        // Reset lands right after an accepted grant; pointer must restart at requester 0.
        @(negedge clk);
        req_valid = 3'b010;
        req_wa    = {5'd3, 5'd5, 5'd1};
        req_wd    = {C0, 32'h55, 32'h77};
        rsv_valid = 1'b0;
        chk_ra2   = 5'd0;
        #1;
        checkOutput("midrst_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 3'b111;
        #1;
        checkOutput("midrst_ready_forced", 32'(req_ready), 32'h0);
        checkOutput("midrst_inflight_wa", 32'(wa), 32'h5);
        @(negedge clk);
        #1;
        checkOutput("midrst_regwrite", 32'(reg_write), 32'h0);
        checkOutput("midrst_pending", pending, 32'h0);
        checkOutput("midrst_rsverr", 32'(rsv_err), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_first_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        checkOutput("midrst_write_en", 32'(reg_write), 32'h1);
        checkOutput("midrst_write_wa", 32'(wa), 32'h1);
        checkOutput("midrst_write_wd", wd, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
